// File: rtl/range_pkg.sv
// Shared widths, defaults and FSM encodings for the trilateration range generator.
package range_pkg;

    localparam int unsigned W_DEF    = 32;
    localparam int unsigned FRAC_DEF = 16;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_DIFF   = 4'd1,
        ST_SQUARE = 4'd2,
        ST_SUM    = 4'd3,
        ST_SQRT   = 4'd4,
        ST_STORE  = 4'd5,
        ST_DONE   = 4'd6
    } state_e;

    // Coordinate difference width (signed, cannot overflow)
    function automatic int unsigned dw_of(input int unsigned w);
        return w + 1;
    endfunction

    // Squared difference width
    function automatic int unsigned sqw_of(input int unsigned w);
        return 2 * w + 2;
    endfunction

    // Sum-of-squares width
    function automatic int unsigned sw_of(input int unsigned w);
        return 2 * w + 4;
    endfunction

    // Root width (one bit per sqrt cycle)
    function automatic int unsigned qw_of(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/isqrt_serial.sv
// Restoring bit-serial integer square root, one root bit per cycle, MSB first.
// Ports: clk, rst_n; start (loads radicand and resolves the first bit on the same edge);
//        radicand[SW]; busy (iterations remaining); valid (root complete, held until next start);
//        root[QW] = floor(sqrt(radicand)).
module isqrt_serial
    import range_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [sw_of(W)-1:0]       radicand,
    output logic                      busy,
    output logic                      valid,
    output logic [qw_of(W)-1:0]       root
);

    localparam int unsigned SW = sw_of(W);
    localparam int unsigned QW = qw_of(W);
    localparam int unsigned CW = $clog2(QW + 1);

    logic [SW-1:0]   rad;
    logic [QW+1:0]   rem;
    logic [CW-1:0]   cnt;

    logic [SW-1:0]   rad_src;
    logic [QW+1:0]   rem_src;
    logic [QW-1:0]   root_src;
    logic [QW+3:0]   rem_sh;
    logic [QW+3:0]   trial;
    logic            ge;
    logic [SW-1:0]   rad_nx;
    logic [QW+1:0]   rem_nx;
    logic [QW-1:0]   root_nx;

    // One restoring step; start seeds it from the fresh radicand
    always_comb begin
        rad_src  = rad;
        rem_src  = rem;
        root_src = root;
        if (start) begin
            rad_src  = radicand;
            rem_src  = '0;
            root_src = '0;
        end
        rem_sh  = {rem_src, rad_src[SW-1 -: 2]};
        trial   = (QW + 4)'({root_src, 2'b01});
        ge      = (rem_sh >= trial);
        rem_nx  = ge ? (QW + 2)'(rem_sh - trial) : (QW + 2)'(rem_sh);
        root_nx = QW'({root_src, ge});
        rad_nx  = rad_src << 2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad   <= '0;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else if (start) begin
            rad   <= rad_nx;
            rem   <= rem_nx;
            root  <= root_nx;
            cnt   <= CW'(1);
            busy  <= 1'b1;
            valid <= 1'b0;
        end else if (busy) begin
            rad  <= rad_nx;
            rem  <= rem_nx;
            root <= root_nx;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(QW - 1)) begin
                busy  <= 1'b0;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/range_generator.sv
// Forward range model: four Euclidean ranges from a target to four anchors, fixed-point.
// Ports: clk, rst_n; en (start, sampled in IDLE); x1..x4/y1..y4/z1..z4 anchors; c1..c3 target;
//        r1..r4 ranges; sat per-range clip flags; busy; done (one-cycle pulse); state (debug).
module range_generator
    import range_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    input  logic [W-1:0] x4,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] y2,
    input  logic [W-1:0] y3,
    input  logic [W-1:0] y4,
    input  logic [W-1:0] z1,
    input  logic [W-1:0] z2,
    input  logic [W-1:0] z3,
    input  logic [W-1:0] z4,
    input  logic [W-1:0] c1,
    input  logic [W-1:0] c2,
    input  logic [W-1:0] c3,
    output logic [W-1:0] r1,
    output logic [W-1:0] r2,
    output logic [W-1:0] r3,
    output logic [W-1:0] r4,
    output logic [3:0]   sat,
    output logic         busy,
    output logic         done,
    output logic [3:0]   state
);

    localparam int unsigned DW  = dw_of(W);
    localparam int unsigned SQW = sqw_of(W);
    localparam int unsigned SW  = sw_of(W);
    localparam int unsigned QW  = qw_of(W);

    if (FRAC >= W) begin : g_bad_frac
        $error("range_generator: FRAC must be smaller than W");
    end

    state_e cur_state, state_d;

    logic [1:0]            k;
    logic signed [W-1:0]   ax [4];
    logic signed [W-1:0]   ay [4];
    logic signed [W-1:0]   az [4];
    logic signed [W-1:0]   tc1, tc2, tc3;
    logic signed [DW-1:0]  dx, dy, dz;
    logic [SQW-1:0]        sqx, sqy, sqz;
    logic [SW-1:0]         sum_c;
    logic [W-1:0]          sh_r  [4];
    logic [3:0]            sh_sat;
    logic [W-1:0]          out_r [4];

    logic                  sq_start;
    logic                  sq_busy;
    logic                  sq_valid;
    logic [QW-1:0]         sq_root;
    logic                  clip_c;

    // The sum of squares is captured straight into the root engine on the SUM edge
    assign sum_c    = SW'(sqx) + SW'(sqy) + SW'(sqz);
    assign sq_start = (cur_state == ST_SUM) && !sq_busy;
    assign clip_c   = |sq_root[QW-1:W];

    isqrt_serial #(.W(W)) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (sq_start),
        .radicand (sum_c),
        .busy     (sq_busy),
        .valid    (sq_valid),
        .root     (sq_root)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= ST_IDLE;
        else        cur_state <= state_d;
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        state_d = cur_state;
        case (cur_state)
            ST_IDLE:   if (en) state_d = ST_DIFF;
            ST_DIFF:   state_d = ST_SQUARE;
            ST_SQUARE: state_d = ST_SUM;
            ST_SUM:    state_d = ST_SQRT;
            ST_SQRT:   if (sq_valid) state_d = ST_STORE;
            ST_STORE:  state_d = (k == 2'd3) ? ST_DONE : ST_DIFF;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath, shadow ranges and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= '0;
            tc1    <= '0;
            tc2    <= '0;
            tc3    <= '0;
            dx     <= '0;
            dy     <= '0;
            dz     <= '0;
            sqx    <= '0;
            sqy    <= '0;
            sqz    <= '0;
            sh_sat <= '0;
            sat    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                ax[i]    <= '0;
                ay[i]    <= '0;
                az[i]    <= '0;
                sh_r[i]  <= '0;
                out_r[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            // Busy stays up through the done cycle
            busy <= (state_d != ST_IDLE) || (cur_state == ST_DONE);
            case (cur_state)
                ST_IDLE: begin
                    if (en) begin
                        ax[0] <= x1; ax[1] <= x2; ax[2] <= x3; ax[3] <= x4;
                        ay[0] <= y1; ay[1] <= y2; ay[2] <= y3; ay[3] <= y4;
                        az[0] <= z1; az[1] <= z2; az[2] <= z3; az[3] <= z4;
                        tc1   <= c1;
                        tc2   <= c2;
                        tc3   <= c3;
                        k     <= '0;
                    end
                end
                ST_DIFF: begin
                    dx <= DW'(ax[k]) - DW'(tc1);
                    dy <= DW'(ay[k]) - DW'(tc2);
                    dz <= DW'(az[k]) - DW'(tc3);
                end
                ST_SQUARE: begin
                    // Sign-extended operands make the low SQW bits the exact square
                    sqx <= $unsigned(SQW'(dx) * SQW'(dx));
                    sqy <= $unsigned(SQW'(dy) * SQW'(dy));
                    sqz <= $unsigned(SQW'(dz) * SQW'(dz));
                end
                ST_STORE: begin
                    sh_r[k]   <= clip_c ? '1 : sq_root[W-1:0];
                    sh_sat[k] <= clip_c;
                    if (k != 2'd3) k <= k + 2'd1;
                end
                ST_DONE: begin
                    for (int i = 0; i < 4; i++) out_r[i] <= sh_r[i];
                    sat  <= sh_sat;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign r1    = out_r[0];
    assign r2    = out_r[1];
    assign r3    = out_r[2];
    assign r4    = out_r[3];
    assign state = cur_state;

endmodule

// File: tb/tb_range_generator.sv
// Directed bench for range_generator: vector table plus multi-cycle corner sequences.
module tb_range_generator;
    import range_pkg::*;

    localparam int unsigned W = 32;
    localparam int LAT = 153;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [W-1:0] x1, x2, x3, x4, y1, y2, y3, y4, z1, z2, z3, z4, c1, c2, c3;
    logic [W-1:0] r1, r2, r3, r4;
    logic [3:0]   sat;
    logic         busy, done;
    logic [3:0]   state;

    range_generator #(.W(W), .FRAC(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .z1(z1), .z2(z2), .z3(z3), .z4(z4),
        .c1(c1), .c2(c2), .c3(c3),
        .r1(r1), .r2(r2), .r3(r3), .r4(r4),
        .sat(sat), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][W-1:0] ax;
        logic [3:0][W-1:0] ay;
        logic [3:0][W-1:0] az;
        logic [2:0][W-1:0] c;
        logic [3:0][W-1:0] er;
        logic [3:0]        esat;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_bad = 0;
    logic [3:0][W-1:0] prev_r;
    logic [3:0]        prev_sat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_a(input int v, input int k, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] z);
        vecs[v].ax[k] = x;
        vecs[v].ay[k] = y;
        vecs[v].az[k] = z;
    endtask

    task automatic set_c(input int v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] cc);
        vecs[v].c[0] = a;
        vecs[v].c[1] = b;
        vecs[v].c[2] = cc;
    endtask

    task automatic set_e(input int v, input logic [W-1:0] e1, input logic [W-1:0] e2,
                         input logic [W-1:0] e3, input logic [W-1:0] e4, input logic [3:0] s);
        vecs[v].er[0] = e1;
        vecs[v].er[1] = e2;
        vecs[v].er[2] = e3;
        vecs[v].er[3] = e4;
        vecs[v].esat  = s;
    endtask

    task automatic drive(input vec_t v);
        x1 = v.ax[0]; x2 = v.ax[1]; x3 = v.ax[2]; x4 = v.ax[3];
        y1 = v.ay[0]; y2 = v.ay[1]; y3 = v.ay[2]; y4 = v.ay[3];
        z1 = v.az[0]; z2 = v.az[1]; z3 = v.az[2]; z4 = v.az[3];
        c1 = v.c[0];  c2 = v.c[1];  c3 = v.c[2];
    endtask

    task automatic scramble();
        x1 = $urandom(); x2 = $urandom(); x3 = $urandom(); x4 = $urandom();
        y1 = $urandom(); y2 = $urandom(); y3 = $urandom(); y4 = $urandom();
        z1 = $urandom(); z2 = $urandom(); z3 = $urandom(); z4 = $urandom();
        c1 = $urandom(); c2 = $urandom(); c3 = $urandom();
    endtask

    // Counts edges until done rises; tracks output changes before it
    task automatic wait_done(input bit poke, output int n, output int hold_bad);
        n = 0;
        hold_bad = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (poke) en = (n == 10 || n == 100);
            if (done) break;
            if ({r4, r3, r2, r1} !== prev_r || sat !== prev_sat) hold_bad++;
        end
        if (poke) en = 1'b0;
    endtask

    task automatic check_results(input string tag, input vec_t v);
        check({tag, " r1"}, 64'(r1), 64'(v.er[0]));
        check({tag, " r2"}, 64'(r2), 64'(v.er[1]));
        check({tag, " r3"}, 64'(r3), 64'(v.er[2]));
        check({tag, " r4"}, 64'(r4), 64'(v.er[3]));
        check({tag, " sat"}, 64'(sat), 64'(v.esat));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " outputs"}, 64'({r4, r3, r2, r1} != '0), 64'(0));
        check({tag, " sat"}, 64'(sat), 64'(0));
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " done"}, 64'(done), 64'(0));
        check({tag, " state"}, 64'(state), 64'(4'(ST_IDLE)));
    endtask

    task automatic run_vec(input int i, input bit poke);
        int n, hb;
        string tag;
        tag = $sformatf("v%0d%s", i, poke ? "p" : "");
        @(negedge clk);
        drive(vecs[i]);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        scramble();
        check({tag, " busy at accept"}, 64'(busy), 64'(1));
        wait_done(poke, n, hb);
        check({tag, " latency"}, 64'(n), 64'(LAT));
        check({tag, " hold"}, 64'(hb), 64'(0));
        check_results(tag, vecs[i]);
        check({tag, " busy in done cycle"}, 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        check({tag, " done width"}, 64'(done), 64'(0));
        check({tag, " busy after"}, 64'(busy), 64'(0));
        prev_r   = vecs[i].er;
        prev_sat = vecs[i].esat;
    endtask

    initial begin
        int n, hb, extra;

        for (int v = 0; v < NV; v++) vecs[v] = '0;
        // Q16.16 hex throughout
        set_c(0, 32'h00030000, 32'h00040000, 32'h0);
        set_e(0, 32'h00050000, 32'h00050000, 32'h00050000, 32'h00050000, 4'b0000);

        set_c(1, 32'h00010000, 32'h00010000, 32'h00010000);
        set_a(1, 1, 32'h00010000, 32'h00010000, 32'h00010000);
        set_a(1, 2, 32'h00020000, 32'h00020000, 32'h00020000);
        set_a(1, 3, 32'h00010000, 32'h00010000, 32'h00040000);
        set_e(1, 32'h0001BB67, 32'h0, 32'h0001BB67, 32'h00030000, 4'b0000);

        set_c(2, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
        set_a(2, 0, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
        set_a(2, 1, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFC0000);
        set_a(2, 2, 32'h80000000, 32'h80000000, 32'h80000000);
        set_a(2, 3, 32'h7FFB0000, 32'h7FFC0000, 32'h7FFF0000);
        set_e(2, 32'h0, 32'h00030000, 32'hFFFFFFFF, 32'h00050000, 4'b0100);

        set_c(3, 32'h00008000, 32'h0, 32'h0);
        set_a(3, 0, 32'hFFFE8000, 32'h0, 32'h0);
        set_a(3, 1, 32'h00008000, 32'h00008000, 32'h0);
        set_a(3, 3, 32'h00008000, 32'h0, 32'h00000001);
        set_e(3, 32'h00020000, 32'h00008000, 32'h00008000, 32'h00000001, 4'b0000);

        set_c(4, 32'hC0000000, 32'h0, 32'h0);
        set_a(4, 0, 32'h40000000, 32'h0, 32'h0);
        set_a(4, 1, 32'h7FFFFFFF, 32'h0, 32'h0);
        set_a(4, 2, 32'h40000000, 32'h80000000, 32'h0);
        set_a(4, 3, 32'h40000000, 32'h80000000, 32'h80000000);
        set_e(4, 32'h80000000, 32'hBFFFFFFF, 32'hB504F333, 32'hDDB3D742, 4'b0000);

        set_c(5, 32'h80000000, 32'h0, 32'h0);
        set_a(5, 0, 32'h7FFFFFFF, 32'h0, 32'h0);
        set_a(5, 1, 32'h7FFFFFFF, 32'h00000001, 32'h0);
        set_a(5, 2, 32'h7FFFFFFF, 32'h00010000, 32'h0);
        set_a(5, 3, 32'h7FFFFFFF, 32'h00020000, 32'h0);
        set_e(5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000);

        drive(vecs[0]);
        prev_r   = '0;
        prev_sat = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset mid-idle");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, 1'b0);

        // en pulses while busy are ignored; no second run afterwards
        run_vec(1, 1'b1);
        extra = 0;
        for (int j = 0; j < 200; j++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("poke extra done", 64'(extra), 64'(0));
        check("poke idle", 64'(state), 64'(4'(ST_IDLE)));

        // en held high: re-accept on the edge after the done cycle
        @(negedge clk);
        drive(vecs[2]);
        en = 1'b1;
        @(posedge clk);
        #1;
        drive(vecs[3]);
        wait_done(1'b0, n, hb);
        check("held first latency", 64'(n), 64'(LAT));
        check("held first hold", 64'(hb), 64'(0));
        check_results("held first", vecs[2]);
        prev_r   = vecs[2].er;
        prev_sat = vecs[2].esat;
        @(posedge clk);
        #1;
        check("held reaccept busy", 64'(busy), 64'(1));
        check("held reaccept state", 64'(state), 64'(4'(ST_DIFF)));
        check("held reaccept done", 64'(done), 64'(0));
        en = 1'b0;
        scramble();
        wait_done(1'b0, n, hb);
        check("held second latency", 64'(n), 64'(LAT));
        check("held second hold", 64'(hb), 64'(0));
        check_results("held second", vecs[3]);
        prev_r   = vecs[3].er;
        prev_sat = vecs[3].esat;
        @(posedge clk);
        #1;

        // Reset mid-run discards partial results
        @(negedge clk);
        drive(vecs[4]);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("reset mid-run");
        @(negedge clk);
        rst_n = 1'b1;
        prev_r   = '0;
        prev_sat = '0;
        run_vec(0, 1'b0);

        // Reset after a completed run
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset after run");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
